// File: rtl/mem_agent_types.sv
// Shared types and defaults for the DDR memory agent.
package mem_agent_types;

  localparam int unsigned RD_BURST_LEN      = 16;
  localparam int unsigned RD_FIFO_DEPTH     = 512;
  localparam int unsigned DEBG_COUNTER_BITS = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_sched_state_e;

  typedef struct packed {
    logic wrreq;
    logic full;
  } fifo_wr_if_t;

endpackage

// File: rtl/mem_agent_credit_cnt.sv
// Up/down counter: +1 on up, -DN_STEP on dn, bounded to [0, MAX_VAL].
module mem_agent_credit_cnt #(
  parameter int unsigned MAX_VAL = 16,
  parameter int unsigned RST_VAL = 0,
  parameter int unsigned DN_STEP = 1,
  localparam int unsigned CW = $clog2(MAX_VAL + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up,
  input  logic          dn,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_nxt_c
);

  localparam logic [CW-1:0] MAX_C  = CW'(MAX_VAL);
  localparam logic [CW-1:0] STEP_C = CW'(DN_STEP);

  always_comb begin
    count_nxt_c = count;
    if (up && !dn) begin
      count_nxt_c = (count == MAX_C) ? count : count + CW'(1);
    end else if (dn && !up) begin
      count_nxt_c = (count >= STEP_C) ? count - STEP_C : '0;
    end else if (up && dn) begin
      count_nxt_c = count + CW'(1) - STEP_C;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= CW'(RST_VAL);
    end else begin
      count <= count_nxt_c;
    end
  end

  // The owner must never ask for a step that leaves the legal range.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (up && !dn) |-> (count != MAX_C));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    dn |-> (({1'b0, count} + (CW + 1)'(up)) >= (CW + 1)'(DN_STEP)));
  a_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    count <= MAX_C);

endmodule

// File: rtl/mem_agent_rd_sched.sv
// Read-side scheduler: walks [RD_BASE, RD_HIGH) with INCR bursts, credit-gated to the read FIFO.
// Define MEM_AGENT_RD_DBG_EN to add the dbg_bursts/dbg_beats/dbg_stall counters.
module mem_agent_rd_sched
  import mem_agent_types::*;
#(
  parameter int unsigned       DATA_W     = 64,
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       BURST_LEN  = RD_BURST_LEN,
  parameter int unsigned       OUTST_MAX  = 16,
  parameter int unsigned       FIFO_DEPTH = RD_FIFO_DEPTH,
  parameter logic [ADDR_W-1:0] RD_BASE    = ADDR_W'(32'h4000_0000),
  parameter logic [ADDR_W-1:0] RD_HIGH    = ADDR_W'(32'h4000_1000)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic              fifo_wrreq,
  input  logic              fifo_full,
  output logic [DATA_W-1:0] fifo_wdata,
  input  logic              fifo_pop
`ifdef MEM_AGENT_RD_DBG_EN
  ,
  output logic [DEBG_COUNTER_BITS-1:0] dbg_bursts,
  output logic [DEBG_COUNTER_BITS-1:0] dbg_beats,
  output logic [DEBG_COUNTER_BITS-1:0] dbg_stall
`endif
);

  localparam int unsigned OW          = $clog2(OUTST_MAX + 1);
  localparam int unsigned CW          = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BURST_BYTES = BURST_LEN * (DATA_W / 8);

  localparam logic [ADDR_W-1:0] BURST_BYTES_A = ADDR_W'(BURST_BYTES);
  localparam logic [ADDR_W:0]   BURST_BYTES_X = (ADDR_W + 1)'(BURST_BYTES);
  localparam logic [ADDR_W:0]   HIGH_X        = {1'b0, RD_HIGH};
  localparam logic [OW-1:0]     OUTST_MAX_C   = OW'(OUTST_MAX);
  localparam logic [CW-1:0]     BURST_LEN_C   = CW'(BURST_LEN);
  localparam logic [7:0]        ARLEN_C       = 8'(BURST_LEN - 1);
  localparam logic [2:0]        ARSIZE_C      = 3'($clog2(DATA_W / 8));

  rd_sched_state_e   state, state_nxt;
  logic [ADDR_W-1:0] araddr_nxt;
  logic              arvalid_nxt;
  logic              err_nxt;
  logic              busy_nxt;
  logic              done_nxt;

  logic [OW-1:0] outst, outst_nxt;
  logic [CW-1:0] credit, credit_nxt;

  logic        ar_hs_c;
  logic        r_beat_c;
  logic        r_last_c;
  logic        r_bad_c;
  logic        room_c;
  logic        room_nxt_c;
  logic        issue_ok_c;
  fifo_wr_if_t fifo_wr;

  // R channel passes straight through to the FIFO write port.
  assign fifo_wr.full  = fifo_full;
  assign fifo_wr.wrreq = m_axi_rvalid & ~fifo_wr.full;
  assign m_axi_rready  = ~fifo_wr.full;
  assign fifo_wrreq    = fifo_wr.wrreq;
  assign fifo_wdata    = m_axi_rdata;

  assign m_axi_arlen   = ARLEN_C;
  assign m_axi_arsize  = ARSIZE_C;
  assign m_axi_arburst = 2'b01;

  assign ar_hs_c  = m_axi_arvalid & m_axi_arready;
  assign r_beat_c = m_axi_rvalid & m_axi_rready;
  assign r_last_c = r_beat_c & m_axi_rlast;
  assign r_bad_c  = r_beat_c & (m_axi_rresp != 2'b00);

  assign room_c     = ({1'b0, m_axi_araddr} + BURST_BYTES_X) <= HIGH_X;
  assign room_nxt_c = ({1'b0, araddr_nxt} + BURST_BYTES_X) <= HIGH_X;

  mem_agent_credit_cnt #(
    .MAX_VAL (OUTST_MAX),
    .RST_VAL (0),
    .DN_STEP (1)
  ) u_outst (
    .clk         (clk),
    .rst_n       (rst_n),
    .up          (ar_hs_c),
    .dn          (r_last_c),
    .count       (outst),
    .count_nxt_c (outst_nxt)
  );

  mem_agent_credit_cnt #(
    .MAX_VAL (FIFO_DEPTH),
    .RST_VAL (FIFO_DEPTH),
    .DN_STEP (BURST_LEN)
  ) u_credit (
    .clk         (clk),
    .rst_n       (rst_n),
    .up          (fifo_pop),
    .dn          (ar_hs_c),
    .count       (credit),
    .count_nxt_c (credit_nxt)
  );

  // Issue decisions look at post-edge counters so back-to-back ARs never overshoot a limit.
  assign issue_ok_c = (outst_nxt < OUTST_MAX_C) && (credit_nxt >= BURST_LEN_C) &&
                      room_nxt_c && !stop && !err_nxt;

  always_comb begin
    state_nxt  = state;
    araddr_nxt = m_axi_araddr;
    err_nxt    = err | r_bad_c;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt  = ISSUE;
          araddr_nxt = RD_BASE;
          err_nxt    = 1'b0;
        end
      end
      ISSUE: begin
        if (ar_hs_c) begin
          araddr_nxt = m_axi_araddr + BURST_BYTES_A;
        end
        if (!m_axi_arvalid && (!room_c || stop || err)) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (outst == '0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    arvalid_nxt = (m_axi_arvalid && !m_axi_arready) || ((state_nxt == ISSUE) && issue_ok_c);
    busy_nxt    = (state_nxt == ISSUE) || (state_nxt == DRAIN);
    done_nxt    = (state_nxt == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      m_axi_araddr  <= RD_BASE;
      m_axi_arvalid <= 1'b0;
      err           <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_nxt;
      m_axi_araddr  <= araddr_nxt;
      m_axi_arvalid <= arvalid_nxt;
      err           <= err_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
    end
  end

`ifdef MEM_AGENT_RD_DBG_EN
  localparam logic [DEBG_COUNTER_BITS-1:0] DBG_MAX = '1;
  localparam logic [DEBG_COUNTER_BITS-1:0] DBG_ONE = DEBG_COUNTER_BITS'(1);

  logic stall_c;

  // A stall is an issue slot lost purely to the credit or outstanding limit.
  assign stall_c = (state == ISSUE) && !m_axi_arvalid && room_c && !stop && !err &&
                   ((outst >= OUTST_MAX_C) || (credit < BURST_LEN_C));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_bursts <= '0;
      dbg_beats  <= '0;
      dbg_stall  <= '0;
    end else if ((state == IDLE) && start) begin
      dbg_bursts <= '0;
      dbg_beats  <= '0;
      dbg_stall  <= '0;
    end else begin
      if (ar_hs_c && (dbg_bursts != DBG_MAX)) dbg_bursts <= dbg_bursts + DBG_ONE;
      if (fifo_wr.wrreq && (dbg_beats != DBG_MAX)) dbg_beats <= dbg_beats + DBG_ONE;
      if (stall_c && (dbg_stall != DBG_MAX)) dbg_stall <= dbg_stall + DBG_ONE;
    end
  end
`endif

endmodule
